// File: rtl/enm_pkg.sv
// enm_pkg: shared types and constants for the enemy-HP / player-bullet block.
//   HP_W, COORD_W    : HP and screen-coordinate widths
//   HP_INIT_DEF      : default HP loaded at reset
//   DAMAGE_DEF       : default HP removed per hit
//   blt_state_e      : bullet FSM state encoding (IDLE / FLY / HIT)
//   sat_sub()        : subtract that clamps at zero instead of wrapping
package enm_pkg;

  localparam int HP_W        = 7;
  localparam int COORD_W     = 10;
  localparam int HP_INIT_DEF = 100;
  localparam int DAMAGE_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_HIT  = 2'd2
  } blt_state_e;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/enm_hit_chk.sv
// enm_hit_chk: combinational box test of the bullet against one enemy.
//   alive_i         : enemy alive flag from the motion block
//   hp_i            : current registered HP of this enemy
//   bltx_i, blty_i  : registered bullet position
//   enmx_i, enmy_i  : enemy centre position
//   hit_o           : bullet lies inside the enemy's hit box and the enemy can be hit
module enm_hit_chk
  import enm_pkg::*;
#(
  parameter int HIT_W = 12,
  parameter int HIT_H = 8
) (
  input  logic               alive_i,
  input  logic [HP_W-1:0]    hp_i,
  input  logic [COORD_W-1:0] bltx_i,
  input  logic [COORD_W-1:0] blty_i,
  input  logic [COORD_W-1:0] enmx_i,
  input  logic [COORD_W-1:0] enmy_i,
  output logic               hit_o
);

  localparam logic [COORD_W:0] HitWC = (COORD_W+1)'(HIT_W);
  localparam logic [COORD_W:0] HitHC = (COORD_W+1)'(HIT_H);

  logic [COORD_W:0] bx, by, ex, ey, dx, dy;

  // Distances are taken one bit wider and always as larger-minus-smaller,
  // so they never wrap regardless of which side the bullet is on.
  assign bx = {1'b0, bltx_i};
  assign by = {1'b0, blty_i};
  assign ex = {1'b0, enmx_i};
  assign ey = {1'b0, enmy_i};
  assign dx = (bx >= ex) ? (bx - ex) : (ex - bx);
  assign dy = (by >= ey) ? (by - ey) : (ey - by);

  // The HP gate masks the cycle after death where the alive flag is still
  // high but the motion block already reports the position as 0,0.
  assign hit_o = alive_i && (hp_i != '0) && (dx < HitWC) && (dy < HitHC);

endmodule

// File: rtl/enm_hp.sv
// enm_hp: owns the player bullet and the HP of the four enemies.
//   clk22                : game tick clock
//   rst                  : asynchronous active-low reset
//   fire                 : synchronised fire button level
//   plyx, plyy           : player position (bullet launch point)
//   enmN, enmxN, enmyN   : enemy alive flag and position from the motion block
//   enmhpN               : registered enemy HP, fed back to the motion block
//   blt_act, bltx, blty  : bullet sprite visible flag and position
//   blt_hit              : explosion display, high while in HIT
//   kills                : number of enemies killed, saturating at 4
//   all_clear            : sticky flag, set the cycle after all HP reach 0
// Optional feature: define ENM_HP_REGEN_EN to enable slow HP regeneration
// of wounded enemies every REGEN_PERIOD cycles.
module enm_hp
  import enm_pkg::*;
#(
  parameter int HP_INIT      = HP_INIT_DEF,
  parameter int DAMAGE       = DAMAGE_DEF,
  parameter int BLT_STEP     = 4,
  parameter int HIT_W        = 12,
  parameter int HIT_H        = 8,
  parameter int HIT_HOLD     = 6
`ifdef ENM_HP_REGEN_EN
  ,
  parameter int REGEN_PERIOD = 64
`endif
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic               fire,
  input  logic [COORD_W-1:0] plyx,
  input  logic [COORD_W-1:0] plyy,
  input  logic               enm1,
  input  logic               enm2,
  input  logic               enm3,
  input  logic               enm4,
  input  logic [COORD_W-1:0] enmx1,
  input  logic [COORD_W-1:0] enmx2,
  input  logic [COORD_W-1:0] enmx3,
  input  logic [COORD_W-1:0] enmx4,
  input  logic [COORD_W-1:0] enmy1,
  input  logic [COORD_W-1:0] enmy2,
  input  logic [COORD_W-1:0] enmy3,
  input  logic [COORD_W-1:0] enmy4,
  output logic [HP_W-1:0]    enmhp1,
  output logic [HP_W-1:0]    enmhp2,
  output logic [HP_W-1:0]    enmhp3,
  output logic [HP_W-1:0]    enmhp4,
  output logic               blt_act,
  output logic [COORD_W-1:0] bltx,
  output logic [COORD_W-1:0] blty,
  output logic               blt_hit,
  output logic [2:0]         kills,
  output logic               all_clear
);

  localparam logic [HP_W-1:0]    HpInitC   = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]    DamageC   = HP_W'(DAMAGE);
  localparam logic [COORD_W-1:0] StepC     = COORD_W'(BLT_STEP);
  localparam int                 HoldW     = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [HoldW-1:0]   HoldLoadC = HoldW'(HIT_HOLD - 1);
  localparam logic [2:0]         KillsMaxC = 3'd4;

  blt_state_e         state_q, state_d;
  logic               fire_q;
  logic               launch;
  logic [COORD_W-1:0] bltx_q, bltx_d, blty_q, blty_d;
  logic               act_q, act_d, bhit_q, bhit_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [2:0]         kills_q, kills_d;
  logic               clear_q, clear_d;
  logic [HP_W-1:0]    hp_q [4];
  logic [HP_W-1:0]    hp_d [4];
  logic               alive [4];
  logic [COORD_W-1:0] ex [4];
  logic [COORD_W-1:0] ey [4];
  logic [3:0]         hit_vec;
  logic [3:0]         dmg_sel;
  logic               regen_tick;

  assign alive[0] = enm1;  assign alive[1] = enm2;
  assign alive[2] = enm3;  assign alive[3] = enm4;
  assign ex[0] = enmx1;    assign ex[1] = enmx2;
  assign ex[2] = enmx3;    assign ex[3] = enmx4;
  assign ey[0] = enmy1;    assign ey[1] = enmy2;
  assign ey[2] = enmy3;    assign ey[3] = enmy4;

  for (genvar g = 0; g < 4; g++) begin : g_chk
    enm_hit_chk #(
      .HIT_W (HIT_W),
      .HIT_H (HIT_H)
    ) u_chk (
      .alive_i (alive[g]),
      .hp_i    (hp_q[g]),
      .bltx_i  (bltx_q),
      .blty_i  (blty_q),
      .enmx_i  (ex[g]),
      .enmy_i  (ey[g]),
      .hit_o   (hit_vec[g])
    );
  end

  assign launch = fire & ~fire_q;

  // Keep only the lowest-index hit (x & -x), and only while the bullet flies.
  assign dmg_sel = (state_q == ST_FLY) ? (hit_vec & (~hit_vec + 4'd1)) : 4'd0;

`ifdef ENM_HP_REGEN_EN
  localparam int              RegW     = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
  localparam logic [RegW-1:0] RegLastC = RegW'(REGEN_PERIOD - 1);

  logic [RegW-1:0] regen_q, regen_d;

  assign regen_tick = (regen_q == RegLastC);
  assign regen_d    = regen_tick ? '0 : regen_q + RegW'(1);

  always_ff @(posedge clk22 or negedge rst) begin
    if (!rst) regen_q <= '0;
    else      regen_q <= regen_d;
  end
`else
  assign regen_tick = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bltx_d  = bltx_q;
    blty_d  = blty_q;
    act_d   = act_q;
    bhit_d  = bhit_q;
    hold_d  = hold_q;
    kills_d = kills_q;
    clear_d = clear_q | ((hp_q[0] == '0) && (hp_q[1] == '0) &&
                         (hp_q[2] == '0) && (hp_q[3] == '0));

    // A damaged enemy skips regeneration in the same cycle; only one enemy
    // is damaged per cycle, so kills advances by at most one.
    for (int i = 0; i < 4; i++) begin
      hp_d[i] = hp_q[i];
      if (dmg_sel[i]) begin
        hp_d[i] = sat_sub(hp_q[i], DamageC);
        if ((hp_d[i] == '0) && (kills_q != KillsMaxC)) kills_d = kills_q + 3'd1;
      end else if (regen_tick && (hp_q[i] != '0) && (hp_q[i] < HpInitC)) begin
        hp_d[i] = hp_q[i] + HP_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        bltx_d = '0;
        blty_d = '0;
        act_d  = 1'b0;
        if (launch) begin
          state_d = ST_FLY;
          bltx_d  = plyx;
          blty_d  = plyy;
          act_d   = 1'b1;
        end
      end
      ST_FLY: begin
        if (|dmg_sel) begin
          state_d = ST_HIT;
          act_d   = 1'b0;
          bhit_d  = 1'b1;
          hold_d  = HoldLoadC;
        end else if (blty_q < StepC) begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
          bltx_d  = '0;
          blty_d  = '0;
        end else begin
          blty_d = blty_q - StepC;
        end
      end
      ST_HIT: begin
        if (hold_q == '0) begin
          state_d = ST_IDLE;
          bhit_d  = 1'b0;
          bltx_d  = '0;
          blty_d  = '0;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk22 or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fire_q  <= 1'b0;
      bltx_q  <= '0;
      blty_q  <= '0;
      act_q   <= 1'b0;
      bhit_q  <= 1'b0;
      hold_q  <= '0;
      kills_q <= '0;
      clear_q <= 1'b0;
      for (int i = 0; i < 4; i++) hp_q[i] <= HpInitC;
    end else begin
      state_q <= state_d;
      fire_q  <= fire;
      bltx_q  <= bltx_d;
      blty_q  <= blty_d;
      act_q   <= act_d;
      bhit_q  <= bhit_d;
      hold_q  <= hold_d;
      kills_q <= kills_d;
      clear_q <= clear_d;
      for (int i = 0; i < 4; i++) hp_q[i] <= hp_d[i];
    end
  end

  assign enmhp1    = hp_q[0];
  assign enmhp2    = hp_q[1];
  assign enmhp3    = hp_q[2];
  assign enmhp4    = hp_q[3];
  assign blt_act   = act_q;
  assign bltx      = bltx_q;
  assign blty      = blty_q;
  assign blt_hit   = bhit_q;
  assign kills     = kills_q;
  assign all_clear = clear_q;

endmodule

// File: tb/tb_enm_hp.sv
`timescale 1ns/1ps
module tb_enm_hp;

  localparam int HP_INIT      = 100;
  localparam int DAMAGE       = 10;
  localparam int BLT_STEP     = 4;
  localparam int HIT_W        = 12;
  localparam int HIT_H        = 8;
  localparam int HIT_HOLD     = 6;
  localparam int REGEN_PERIOD = 64;

  logic       clk22 = 1'b0;
  logic       rst   = 1'b1;
  logic       fire  = 1'b0;
  logic [9:0] plyx  = '0;
  logic [9:0] plyy  = '0;
  logic       enm1, enm2, enm3, enm4;
  logic [9:0] enmx1, enmx2, enmx3, enmx4;
  logic [9:0] enmy1, enmy2, enmy3, enmy4;
  logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
  logic       blt_act;
  logic [9:0] bltx, blty;
  logic       blt_hit;
  logic [2:0] kills;
  logic       all_clear;

  enm_hp dut (
    .clk22(clk22), .rst(rst), .fire(fire), .plyx(plyx), .plyy(plyy),
    .enm1(enm1), .enm2(enm2), .enm3(enm3), .enm4(enm4),
    .enmx1(enmx1), .enmx2(enmx2), .enmx3(enmx3), .enmx4(enmx4),
    .enmy1(enmy1), .enmy2(enmy2), .enmy3(enmy3), .enmy4(enmy4),
    .enmhp1(enmhp1), .enmhp2(enmhp2), .enmhp3(enmhp3), .enmhp4(enmhp4),
    .blt_act(blt_act), .bltx(bltx), .blty(blty), .blt_hit(blt_hit),
    .kills(kills), .all_clear(all_clear)
  );

  always #5 clk22 = ~clk22;

  int errors = 0;
  int checks = 0;

  // Enemy stimulus as the bench sees it.
  bit eAlive [4];
  int eX [4];
  int eY [4];

  // Behavioural model of the game rules.
  int mHp [4];
  int mKills;
  bit mClear;
  bit mPrevFire;
  bit mFlying;
  int mBoom;
  int mBx, mBy;
  int mTick;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mHp[i] = HP_INIT;
    mKills = 0; mClear = 0; mPrevFire = 0; mFlying = 0;
    mBoom = 0; mBx = 0; mBy = 0; mTick = 0;
  endtask

  task automatic modelStep();
    bit launch;
    bit allZero;
    int target;
    int oldHp [4];
    launch    = fire && !mPrevFire;
    mPrevFire = fire;
    oldHp     = mHp;
    allZero   = 1;
    for (int i = 0; i < 4; i++) if (oldHp[i] != 0) allZero = 0;
    target = -1;
    if (mBoom > 0) begin
      mBoom--;
      if (mBoom == 0) begin mBx = 0; mBy = 0; end
    end else if (mFlying) begin
      for (int i = 0; i < 4; i++)
        if (target < 0 && eAlive[i] && mHp[i] > 0 &&
            absd(mBx, eX[i]) < HIT_W && absd(mBy, eY[i]) < HIT_H) target = i;
      if (target >= 0) begin
        mHp[target] = (mHp[target] > DAMAGE) ? mHp[target] - DAMAGE : 0;
        if (mHp[target] == 0 && mKills < 4) mKills++;
        mFlying = 0;
        mBoom   = HIT_HOLD;
      end else if (mBy < BLT_STEP) begin
        mFlying = 0; mBx = 0; mBy = 0;
      end else begin
        mBy -= BLT_STEP;
      end
    end else if (launch) begin
      mFlying = 1; mBx = plyx; mBy = plyy;
    end
`ifdef ENM_HP_REGEN_EN
    if (mTick == REGEN_PERIOD - 1)
      for (int i = 0; i < 4; i++)
        if (i != target && oldHp[i] > 0 && oldHp[i] < HP_INIT) mHp[i] = oldHp[i] + 1;
    mTick = (mTick + 1) % REGEN_PERIOD;
`endif
    if (allZero) mClear = 1;
  endtask

  task automatic checkOutput();
    checkVal("enmhp1", enmhp1, mHp[0]);
    checkVal("enmhp2", enmhp2, mHp[1]);
    checkVal("enmhp3", enmhp3, mHp[2]);
    checkVal("enmhp4", enmhp4, mHp[3]);
    checkVal("blt_act", blt_act, mFlying);
    checkVal("bltx", bltx, mBx);
    checkVal("blty", blty, mBy);
    checkVal("blt_hit", blt_hit, (mBoom > 0) ? 1 : 0);
    checkVal("kills", kills, mKills);
    checkVal("all_clear", all_clear, mClear);
  endtask

  task automatic driveEnemies();
    enm1 = eAlive[0]; enm2 = eAlive[1]; enm3 = eAlive[2]; enm4 = eAlive[3];
    enmx1 = 10'(eX[0]); enmx2 = 10'(eX[1]); enmx3 = 10'(eX[2]); enmx4 = 10'(eX[3]);
    enmy1 = 10'(eY[0]); enmy2 = 10'(eY[1]); enmy3 = 10'(eY[2]); enmy4 = 10'(eY[3]);
  endtask

  task automatic placeEnemies(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3);
    eX[0] = x0; eY[0] = y0; eX[1] = x1; eY[1] = y1;
    eX[2] = x2; eY[2] = y2; eX[3] = x3; eY[3] = y3;
    for (int i = 0; i < 4; i++) eAlive[i] = 1;
    driveEnemies();
  endtask

  // One clock: model follows the rising edge, outputs compared on the falling edge.
  task automatic stepCycle();
    @(posedge clk22);
    modelStep();
    @(negedge clk22);
    checkOutput();
  endtask

  // Asserted between edges to exercise the asynchronous path.
  task automatic pulseReset();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput();
    checkVal("rst_blt_act", blt_act, 0);
    checkVal("rst_blt_hit", blt_hit, 0);
    checkVal("rst_enmhp1", enmhp1, 100);
    checkVal("rst_kills", kills, 0);
    checkVal("rst_all_clear", all_clear, 0);
    @(negedge clk22);
    rst = 1'b1;
  endtask

  task automatic fireShot();
    bit done;
    fire = 1'b1;
    stepCycle();
    fire = 1'b0;
    done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      stepCycle();
      if (!mFlying && mBoom == 0) done = 1;
    end
    if (!done) begin
      errors++; checks++;
      $display("[TB] FAIL shot_timeout: got busy, expected idle within 400 cycles");
    end
  endtask

  task automatic applyStimulus();
    int k;
    fire = ($urandom_range(0, 5) == 0);
    if ($urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, 3);
      plyx = 10'(clip(eX[k] + int'($urandom_range(0, 30)) - 15));
      plyy = 10'(clip(eY[k] + int'($urandom_range(0, 80))));
    end else if ($urandom_range(0, 7) == 0) begin
      plyx = 10'($urandom_range(0, 1023));
      plyy = 10'($urandom_range(0, 1023));
    end
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) eY[i] = clip(eY[i] + int'($urandom_range(0, 4)) - 2);
      if ($urandom_range(0, 63) == 0) eAlive[i] = !eAlive[i];
    end
    driveEnemies();
  endtask

  initial begin
    int launches;
    bit prevAct;

    placeEnemies(40, 220, 600, 50, 700, 50, 800, 50);
    modelReset();
    #1 rst = 1'b0;
    @(negedge clk22);
    checkOutput();
    checkVal("init_enmhp1", enmhp1, 100);
    checkVal("init_blt_act", blt_act, 0);
    checkVal("init_kills", kills, 0);
    rst = 1'b1;

    $display("[TB] direct hit");
    plyx = 10'd40; plyy = 10'd400;
    fire = 1'b1;
    stepCycle();
    checkVal("launch_act", blt_act, 1);
    checkVal("launch_y", blty, 400);
    checkVal("launch_x", bltx, 40);
    fire = 1'b0;
    stepCycle();
    checkVal("step_y", blty, 396);
    repeat (44) stepCycle();
    checkVal("hit_hp1", enmhp1, 90);
    checkVal("hit_flag", blt_hit, 1);
    checkVal("hit_y", blty, 224);
    checkVal("hit_act", blt_act, 0);
    repeat (5) stepCycle();
    checkVal("hold_last", blt_hit, 1);
    stepCycle();
    checkVal("hold_end", blt_hit, 0);

    $display("[TB] kill enemy 1");
    repeat (9) fireShot();
`ifndef ENM_HP_REGEN_EN
    checkVal("kill_hp1", enmhp1, 0);
    checkVal("kill_count", kills, 1);
`endif
    fireShot();
`ifndef ENM_HP_REGEN_EN
    checkVal("dead_pass_hp1", enmhp1, 0);
    checkVal("dead_pass_kills", kills, 1);
`endif

    $display("[TB] overlap priority");
    pulseReset();
    placeEnemies(140, 100, 140, 100, 700, 50, 800, 50);
    plyx = 10'd140; plyy = 10'd400;
    fireShot();
    checkVal("ovl_hp1", enmhp1, 90);
    checkVal("ovl_hp2", enmhp2, 100);

    $display("[TB] miss, held fire and mid-flight refire");
    pulseReset();
    placeEnemies(600, 220, 700, 220, 800, 220, 900, 220);
    plyx = 10'd200; plyy = 10'd400;
    launches = 0; prevAct = 0;
    fire = 1'b1;
    for (int n = 0; n < 200; n++) begin
      stepCycle();
      if (blt_act && !prevAct) launches++;
      prevAct = blt_act;
    end
    checkVal("held_launches", launches, 1);
    fire = 1'b0;
    stepCycle();
    launches = 0; prevAct = 0;
    fire = 1'b1;
    stepCycle();
    if (blt_act && !prevAct) launches++;
    prevAct = blt_act;
    fire = 1'b0;
    for (int n = 0; n < 150; n++) begin
      fire = (n == 5);
      stepCycle();
      if (blt_act && !prevAct) launches++;
      prevAct = blt_act;
    end
    fire = 1'b0;
    checkVal("refire_launches", launches, 1);
    checkVal("miss_hp1", enmhp1, 100);
    checkVal("miss_hp4", enmhp4, 100);
    checkVal("miss_kills", kills, 0);

    $display("[TB] reset mid-flight");
    pulseReset();
    placeEnemies(40, 220, 600, 50, 700, 50, 800, 50);
    plyx = 10'd40; plyy = 10'd400;
    repeat (5) fireShot();
`ifndef ENM_HP_REGEN_EN
    checkVal("pre_rst_hp1", enmhp1, 50);
`endif
    fire = 1'b1;
    stepCycle();
    fire = 1'b0;
    for (int n = 0; n < 100 && mBy != 300; n++) stepCycle();
    checkVal("mid_y", blty, 300);
    pulseReset();

`ifdef ENM_HP_REGEN_EN
    $display("[TB] regeneration");
    fireShot();
    checkVal("regen_start", enmhp1, 90);
    repeat (11 * REGEN_PERIOD) stepCycle();
    checkVal("regen_full", enmhp1, 100);
`endif

    $display("[TB] randomized play");
    for (int i = 0; i < 4; i++) begin
      eX[i] = $urandom_range(50, 950);
      eY[i] = $urandom_range(100, 500);
      eAlive[i] = 1;
    end
    driveEnemies();
    for (int n = 0; n < 6000; n++) begin
      applyStimulus();
      stepCycle();
      if ($urandom_range(0, 1499) == 0) pulseReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
